// File: rtl/round_timer.sv
// Multi-round tick timer: sequences NUM_ROUNDS rounds of ROUND_LEN+1 ticks
// with start, pause and up/down display modes on the 1 Hz clock.
module round_timer #(
  parameter int WIDTH      = 7,
  parameter int ROUND_LEN  = 12,
  parameter int NUM_ROUNDS = 3,
  parameter int RW         = 2
) (
  input  logic             clock_div_1Hz,
  input  logic             total_reset,
  input  logic             start,
  input  logic             pause,
  input  logic             count_down,
  output logic [WIDTH-1:0] current_time,
  output logic [RW-1:0]    round_num,
  output logic             round_reset,
  output logic             game_over,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LAST_TICK = WIDTH'(ROUND_LEN);
  localparam logic [RW-1:0]    LAST_RND  = RW'(NUM_ROUNDS - 1);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] el_q, el_d;
  logic [RW-1:0]    rn_q, rn_d;
  logic             rr_q, rr_d;
  logic             go_q, go_d;

  always_ff @(posedge clock_div_1Hz) begin
    if (total_reset) begin
      st_q <= IDLE;
      el_q <= '0;
      rn_q <= '0;
      rr_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      st_q <= st_d;
      el_q <= el_d;
      rn_q <= rn_d;
      rr_q <= rr_d;
      go_q <= go_d;
    end
  end

  always_comb begin
    st_d = st_q;
    el_d = el_q;
    rn_d = rn_q;
    rr_d = rr_q;
    go_d = go_q;
    unique case (st_q)
      IDLE: begin
        el_d = '0;
        rn_d = '0;
        rr_d = 1'b0;
        go_d = 1'b0;
        if (start) begin
          st_d = RUN;
          rr_d = 1'b1;
        end
      end
      RUN: begin
        // pause outranks the wrap so a paused round never loses its last tick
        if (pause) begin
          st_d = PAUSED;
          rr_d = 1'b1;
        end else if (el_q == LAST_TICK) begin
          el_d = '0;
          rr_d = 1'b0;
          if (rn_q == LAST_RND) begin
            st_d = DONE;
            go_d = 1'b1;
          end else begin
            rn_d = rn_q + 1'b1;
          end
        end else begin
          el_d = el_q + 1'b1;
          rr_d = 1'b1;
        end
      end
      PAUSED: begin
        rr_d = 1'b1;
        if (!pause) st_d = RUN;
      end
      DONE: begin
        el_d = '0;
        rr_d = 1'b0;
        go_d = 1'b1;
        if (start) begin
          st_d = RUN;
          rn_d = '0;
          go_d = 1'b0;
          rr_d = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign current_time = count_down ? (LAST_TICK - el_q) : el_q;
  assign round_num    = rn_q;
  assign round_reset  = rr_q;
  assign game_over    = go_q;
  assign state        = st_q;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: reset, counting, display mode,
// pause, pause-at-wrap, full game and mid-round reset.
module tb_round_timer;

  logic       clk;
  logic       total_reset;
  logic       start;
  logic       pause;
  logic       count_down;
  logic [6:0] current_time;
  logic [1:0] round_num;
  logic       round_reset;
  logic       game_over;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  round_timer dut (
    .clock_div_1Hz(clk),
    .total_reset  (total_reset),
    .start        (start),
    .pause        (pause),
    .count_down   (count_down),
    .current_time (current_time),
    .round_num    (round_num),
    .round_reset  (round_reset),
    .game_over    (game_over),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int ct,
                         input int rn, input int rr, input int go);
    chk({tag, ".state"}, int'(state), st);
    chk({tag, ".time"}, int'(current_time), ct);
    chk({tag, ".round"}, int'(round_num), rn);
    chk({tag, ".rr"}, int'(round_reset), rr);
    chk({tag, ".go"}, int'(game_over), go);
  endtask

  task automatic restart();
    total_reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    tick();
    total_reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    total_reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    count_down = 1'b0;

    // reset state, both display modes
    tick();
    chk_all("reset", 0, 0, 0, 0, 0);
    count_down = 1'b1;
    #1;
    chk("reset_down.time", int'(current_time), 12);
    count_down = 1'b0;

    // IDLE ignores pause
    total_reset = 1'b0;
    pause = 1'b1;
    tick();
    chk_all("idle_pause", 0, 0, 0, 0, 0);
    pause = 1'b0;

    // 1) count up through one round and the wrap
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("start", 1, 0, 0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("up.time", int'(current_time), i);
      chk("up.rr", int'(round_reset), 1);
    end
    tick();
    chk_all("up_wrap", 1, 0, 1, 0, 0);
    tick();
    chk_all("up_after", 1, 1, 1, 1, 0);

    // 2) count-down display
    count_down = 1'b1;
    restart();
    chk("down0.time", int'(current_time), 12);
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("down.time", int'(current_time), 12 - i);
    end
    tick();
    chk_all("down_wrap", 1, 12, 1, 0, 0);
    tick();
    tick();
    chk("down_mid.time", int'(current_time), 10);
    count_down = 1'b0;
    #1;
    chk("flip_up.time", int'(current_time), 2);
    count_down = 1'b1;
    #1;
    chk("flip_down.time", int'(current_time), 10);
    count_down = 1'b0;

    // 3) pause at time 5 for three edges
    restart();
    repeat (5) tick();
    chk("pre_pause.time", int'(current_time), 5);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("paused", 2, 5, 0, 1, 0);
    end
    start = 1'b1;
    tick();
    chk_all("paused_start", 2, 5, 0, 1, 0);
    start = 1'b0;
    pause = 1'b0;
    tick();
    chk_all("resume", 1, 5, 0, 1, 0);
    tick();
    chk_all("resume_next", 1, 6, 0, 1, 0);

    // 4) pause on the wrap edge
    repeat (6) tick();
    chk("at12.time", int'(current_time), 12);
    pause = 1'b1;
    tick();
    chk_all("pause_at12", 2, 12, 0, 1, 0);
    pause = 1'b0;
    tick();
    chk_all("release12", 1, 12, 0, 1, 0);
    tick();
    chk_all("late_wrap", 1, 0, 1, 0, 0);
    tick();
    chk_all("late_wrap_next", 1, 1, 1, 1, 0);

    // 5) full game
    restart();
    repeat (38) tick();
    chk_all("last_tick", 1, 12, 2, 1, 0);
    tick();
    chk_all("done", 3, 0, 2, 0, 1);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("done_hold", 3, 0, 2, 0, 1);
    end
    pause = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("restart", 1, 0, 0, 1, 0);

    // 6) reset mid-round with start held
    repeat (13) tick();
    repeat (7) tick();
    chk_all("mid_round", 1, 7, 1, 1, 0);
    start = 1'b1;
    total_reset = 1'b1;
    tick();
    chk_all("mid_reset", 0, 0, 0, 0, 0);
    tick();
    chk_all("reset_held", 0, 0, 0, 0, 0);
    total_reset = 1'b0;
    tick();
    chk_all("post_reset_start", 1, 0, 0, 1, 0);
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
